// File: rtl/pomo_session_sched.sv
`default_nettype none
// ============================================================================
//  Module      : pomo_session_sched
//  Description : Pomodoro phase sequencer (work / short / long break) driving
//                the countdown engine load/run and the alarm. Optional build
//                macro AUTO_ADVANCE_EN starts the next period after an alarm.
//  Revision    : 1.0  initial release
// ============================================================================
module pomo_session_sched #(
    parameter int WORK_MIN   = 25,
    parameter int SHORT_MIN  = 5,
    parameter int LONG_MIN   = 15,
    parameter int LONG_EVERY = 4,
    parameter int ALARM_CLKS = 12000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_start,
    input  logic       btn_skip,
    input  logic       tmr_done,
    output logic       tmr_load,
    output logic [7:0] tmr_minutes,
    output logic       tmr_run,
    output logic [1:0] phase,
    output logic       alarm,
    output logic [7:0] pomo_count
);

    localparam int AW = $clog2(ALARM_CLKS + 1);
    localparam int SW = $clog2(LONG_EVERY + 1);

    localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_CLKS - 1);
    localparam logic [SW-1:0] SET_FULL   = SW'(LONG_EVERY);
    localparam logic [7:0]    WORK_LEN   = 8'(WORK_MIN);
    localparam logic [7:0]    SHORT_LEN  = 8'(SHORT_MIN);
    localparam logic [7:0]    LONG_LEN   = 8'(LONG_MIN);

    typedef enum logic [2:0] {
        S_LOAD  = 3'd0,
        S_IDLE  = 3'd1,
        S_RUN   = 3'd2,
        S_PAUSE = 3'd3,
        S_ALARM = 3'd4,
        S_NEXT  = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        PH_WORK  = 2'd0,
        PH_SHORT = 2'd1,
        PH_LONG  = 2'd2
    } phase_t;

    state_t          state,       state_nxt;
    phase_t          phase_q,     phase_nxt;
    logic [7:0]      minutes_nxt;
    logic [7:0]      pomo_nxt;
    logic [SW-1:0]   set_idx,     set_idx_nxt;
    logic [AW-1:0]   alarm_cnt,   alarm_cnt_nxt;
    logic            load_nxt;
    logic            run_nxt;
    logic            alarm_nxt;
`ifdef AUTO_ADVANCE_EN
    logic            from_alarm,  from_alarm_nxt;
`endif

    assign phase = phase_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_LOAD;
            phase_q     <= PH_WORK;
            tmr_minutes <= WORK_LEN;
            set_idx     <= '0;
            pomo_count  <= 8'd0;
            alarm_cnt   <= '0;
            tmr_load    <= 1'b0;
            tmr_run     <= 1'b0;
            alarm       <= 1'b0;
`ifdef AUTO_ADVANCE_EN
            from_alarm  <= 1'b0;
`endif
        end else begin
            state       <= state_nxt;
            phase_q     <= phase_nxt;
            tmr_minutes <= minutes_nxt;
            set_idx     <= set_idx_nxt;
            pomo_count  <= pomo_nxt;
            alarm_cnt   <= alarm_cnt_nxt;
            tmr_load    <= load_nxt;
            tmr_run     <= run_nxt;
            alarm       <= alarm_nxt;
`ifdef AUTO_ADVANCE_EN
            from_alarm  <= from_alarm_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt      = state;
        phase_nxt      = phase_q;
        minutes_nxt    = tmr_minutes;
        set_idx_nxt    = set_idx;
        pomo_nxt       = pomo_count;
        alarm_cnt_nxt  = alarm_cnt;
`ifdef AUTO_ADVANCE_EN
        from_alarm_nxt = from_alarm;
`endif

        case (state)
            // LOAD is held one extra cycle after reset so the pulse is issued
            // on the first clock with rst_n high; entered from NEXT the pulse
            // is already up and LOAD lasts exactly one cycle.
            S_LOAD: begin
                if (tmr_load) begin
`ifdef AUTO_ADVANCE_EN
                    state_nxt      = from_alarm ? S_RUN : S_IDLE;
                    from_alarm_nxt = 1'b0;
`else
                    state_nxt      = S_IDLE;
`endif
                end
            end
            S_IDLE: begin
                if (btn_skip) begin
                    state_nxt = S_NEXT;
                end else if (btn_start) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (tmr_done) begin
                    state_nxt     = S_ALARM;
                    alarm_cnt_nxt = '0;
                    if (phase_q == PH_WORK) begin
                        pomo_nxt    = pomo_count + 8'd1;
                        set_idx_nxt = set_idx + 1'b1;
                    end
                end else if (btn_skip) begin
                    state_nxt = S_NEXT;
                end else if (btn_start) begin
                    state_nxt = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (btn_skip) begin
                    state_nxt = S_NEXT;
                end else if (btn_start) begin
                    state_nxt = S_RUN;
                end
            end
            S_ALARM: begin
                if (btn_start || (alarm_cnt == ALARM_LAST)) begin
                    state_nxt      = S_NEXT;
`ifdef AUTO_ADVANCE_EN
                    from_alarm_nxt = 1'b1;
`endif
                end else begin
                    alarm_cnt_nxt = alarm_cnt + 1'b1;
                end
            end
            S_NEXT: begin
                state_nxt = S_LOAD;
                if (phase_q == PH_WORK) begin
                    if (set_idx == SET_FULL) begin
                        phase_nxt   = PH_LONG;
                        minutes_nxt = LONG_LEN;
                        set_idx_nxt = '0;
                    end else begin
                        phase_nxt   = PH_SHORT;
                        minutes_nxt = SHORT_LEN;
                    end
                end else begin
                    phase_nxt   = PH_WORK;
                    minutes_nxt = WORK_LEN;
                end
            end
            default: begin
                state_nxt      = S_LOAD;
                phase_nxt      = PH_WORK;
                minutes_nxt    = WORK_LEN;
                set_idx_nxt    = '0;
                pomo_nxt       = 8'd0;
                alarm_cnt_nxt  = '0;
`ifdef AUTO_ADVANCE_EN
                from_alarm_nxt = 1'b0;
`endif
            end
        endcase

        load_nxt  = (state_nxt == S_LOAD) && !((state == S_LOAD) && tmr_load);
        run_nxt   = (state_nxt == S_RUN);
        alarm_nxt = (state_nxt == S_ALARM);
    end

endmodule
`default_nettype wire

// File: tb/tb_pomo_session_sched.sv
`default_nettype none
// Directed bench for pomo_session_sched; every tmr_load pulse is matched
// against a scoreboard of expected {minutes, phase, pomo_count}.
module tb_pomo_session_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_start;
    logic       btn_skip;
    logic       tmr_done;
    logic       tmr_load;
    logic [7:0] tmr_minutes;
    logic       tmr_run;
    logic [1:0] phase;
    logic       alarm;
    logic [7:0] pomo_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] minutes;
        logic [1:0] ph;
        logic [7:0] pc;
    } load_exp_t;

    load_exp_t sb[$];

    always #5 clk = ~clk;

    pomo_session_sched #(
        .WORK_MIN  (3),
        .SHORT_MIN (1),
        .LONG_MIN  (2),
        .LONG_EVERY(2),
        .ALARM_CLKS(8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_start  (btn_start),
        .btn_skip   (btn_skip),
        .tmr_done   (tmr_done),
        .tmr_load   (tmr_load),
        .tmr_minutes(tmr_minutes),
        .tmr_run    (tmr_run),
        .phase      (phase),
        .alarm      (alarm),
        .pomo_count (pomo_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_load(input logic [7:0] m, input logic [1:0] p, input logic [7:0] c);
        load_exp_t e;
        e.minutes = m;
        e.ph      = p;
        e.pc      = c;
        sb.push_back(e);
    endtask

    // Scoreboard consumer: one entry per observed tmr_load cycle.
    always begin
        @(posedge clk);
        #2;
        if (tmr_load === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_load", 32'(tmr_load), 32'd0);
            end else begin
                load_exp_t e;
                e = sb.pop_front();
                chk("load_minutes", 32'(tmr_minutes), 32'(e.minutes));
                chk("load_phase",   32'(phase),       32'(e.ph));
                chk("load_pomo",    32'(pomo_count),  32'(e.pc));
            end
        end
    end

    // Counts alarm-high cycles from the current one; exits with alarm low.
    task automatic wait_alarm_end(output int n);
        n = 0;
        for (int i = 0; i < 30; i++) begin
            if (alarm !== 1'b1) break;
            n++;
            tick();
        end
        if (alarm === 1'b1) chk("alarm_timeout", 32'(alarm), 32'd0);
    endtask

    // From IDLE: start, run, done, let the alarm time out, land in next IDLE.
    task automatic complete_period(input int run_cycles);
        int n;
        btn_start = 1'b1; tick(); btn_start = 1'b0;
        repeat (run_cycles) tick();
        tmr_done = 1'b1; tick(); tmr_done = 1'b0;
        wait_alarm_end(n);
        tick();
        tick();
    endtask

    initial begin
        int n;
        rst_n = 1'b0; btn_start = 1'b0; btn_skip = 1'b0; tmr_done = 1'b0;
        repeat (3) tick();

        // Reset values
        chk("rst_load",    32'(tmr_load),    32'd0);
        chk("rst_run",     32'(tmr_run),     32'd0);
        chk("rst_alarm",   32'(alarm),       32'd0);
        chk("rst_phase",   32'(phase),       32'd0);
        chk("rst_minutes", 32'(tmr_minutes), 32'd3);
        chk("rst_pomo",    32'(pomo_count),  32'd0);

        push_load(8'd3, 2'd0, 8'd0);
        rst_n = 1'b1;
        tick();
        chk("first_load", 32'(tmr_load), 32'd1);
        tick();
        chk("load_one_cycle", 32'(tmr_load), 32'd0);
        chk("idle_run",       32'(tmr_run),  32'd0);

        // Work period with 20 run cycles, alarm times out
        btn_start = 1'b1; tick(); btn_start = 1'b0;
        chk("run_latency", 32'(tmr_run), 32'd1);
        repeat (19) tick();
        chk("run_held", 32'(tmr_run), 32'd1);
        push_load(8'd1, 2'd1, 8'd1);
        tmr_done = 1'b1; tick(); tmr_done = 1'b0;
        chk("alarm_on_done", 32'(tmr_run),    32'd0);
        chk("pomo_after_1",  32'(pomo_count), 32'd1);
        wait_alarm_end(n);
        chk("alarm_len", 32'(n), 32'd8);
        tick();
        tick();

        // Short, then second work -> long break, then back to work
        push_load(8'd3, 2'd0, 8'd1);
        complete_period(5);
        push_load(8'd2, 2'd2, 8'd2);
        complete_period(5);
        chk("long_phase",   32'(phase),       32'd2);
        chk("long_minutes", 32'(tmr_minutes), 32'd2);

        // tmr_done while IDLE is dropped
        tmr_done = 1'b1; tick(); tmr_done = 1'b0;
        tick();
        chk("idle_done_alarm", 32'(alarm),      32'd0);
        chk("idle_done_pomo",  32'(pomo_count), 32'd2);

        push_load(8'd3, 2'd0, 8'd2);
        complete_period(4);
        chk("after_long_phase", 32'(phase), 32'd0);

        // Pause ignores tmr_done
        btn_start = 1'b1; tick(); btn_start = 1'b0;
        chk("p_run1", 32'(tmr_run), 32'd1);
        repeat (3) tick();
        btn_start = 1'b1; tick(); btn_start = 1'b0;
        chk("p_paused", 32'(tmr_run), 32'd0);
        tmr_done = 1'b1; tick(); tmr_done = 1'b0;
        tick();
        chk("p_alarm", 32'(alarm),      32'd0);
        chk("p_pomo",  32'(pomo_count), 32'd2);
        btn_start = 1'b1; tick(); btn_start = 1'b0;
        chk("p_run2", 32'(tmr_run), 32'd1);

        // done + skip together in RUN: alarm wins, credit given
        push_load(8'd1, 2'd1, 8'd3);
        tmr_done = 1'b1; btn_skip = 1'b1; tick(); tmr_done = 1'b0; btn_skip = 1'b0;
        chk("ds_alarm", 32'(alarm),      32'd1);
        chk("ds_pomo",  32'(pomo_count), 32'd3);
        wait_alarm_end(n);
        tick();
        tick();
        chk("ds_short", 32'(phase), 32'd1);

        // Skip the short break, then skip a work period from IDLE
        push_load(8'd3, 2'd0, 8'd3);
        btn_skip = 1'b1; tick(); btn_skip = 1'b0;
        tick(); tick();
        push_load(8'd1, 2'd1, 8'd3);
        btn_skip = 1'b1; tick(); btn_skip = 1'b0;
        tick(); tick();
        chk("skip_work_phase", 32'(phase),      32'd1);
        chk("skip_work_pomo",  32'(pomo_count), 32'd3);

        // Reset during ALARM
        btn_start = 1'b1; tick(); btn_start = 1'b0;
        repeat (2) tick();
        tmr_done = 1'b1; tick(); tmr_done = 1'b0;
        tick();
        chk("pre_rst_alarm", 32'(alarm), 32'd1);
        rst_n = 1'b0; tick();
        chk("mid_rst_alarm",   32'(alarm),       32'd0);
        chk("mid_rst_run",     32'(tmr_run),     32'd0);
        chk("mid_rst_load",    32'(tmr_load),    32'd0);
        chk("mid_rst_phase",   32'(phase),       32'd0);
        chk("mid_rst_minutes", 32'(tmr_minutes), 32'd3);
        chk("mid_rst_pomo",    32'(pomo_count),  32'd0);
        push_load(8'd3, 2'd0, 8'd0);
        rst_n = 1'b1;
        tick(); tick();

        // Acknowledge the alarm with btn_start
        btn_start = 1'b1; tick(); btn_start = 1'b0;
        repeat (3) tick();
        push_load(8'd1, 2'd1, 8'd1);
        tmr_done = 1'b1; tick(); tmr_done = 1'b0;
        chk("ack_alarm_on", 32'(alarm), 32'd1);
        btn_start = 1'b1; tick(); btn_start = 1'b0;
        chk("ack_alarm_off", 32'(alarm), 32'd0);
        tick();
        chk("ack_load", 32'(tmr_load), 32'd1);
        tick();
`ifdef AUTO_ADVANCE_EN
        chk("ack_auto_run", 32'(tmr_run), 32'd1);
`else
        chk("ack_auto_run", 32'(tmr_run), 32'd0);
`endif
        tick();
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
